// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encoding and coin values for the vending controller
package vending_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COLLECT = 2'b01;
    localparam logic [1:0] VEND    = 2'b10;
    localparam logic [1:0] CHANGE  = 2'b11;

    // Coin values in 50c units
    localparam int VAL_C = 1;
    localparam int VAL_R = 2;

endpackage

// File: rtl/vend_change_out.sv
// rtl/vend_change_out.sv - greedy one-coin-per-cycle change decomposition
module vend_change_out
    import vending_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] credit,
    output logic         chg_r,
    output logic         chg_c,
    output logic [W-1:0] credit_nxt
);

    localparam logic [W-1:0] R_UNITS = W'(VAL_R);
    localparam logic [W-1:0] C_UNITS = W'(VAL_C);

    // Pay out the largest coin that still fits in the remaining credit
    always_comb begin
        chg_r      = 1'b0;
        chg_c      = 1'b0;
        credit_nxt = credit;
        if (credit >= R_UNITS) begin
            chg_r      = 1'b1;
            credit_nxt = credit - R_UNITS;
        end else if (credit >= C_UNITS) begin
            chg_c      = 1'b1;
            credit_nxt = credit - C_UNITS;
        end
    end

endmodule

// File: rtl/vending_ctrl.sv
// rtl/vending_ctrl.sv - coin credit FSM with dispense handshake, timeout and change return
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int PRICE      = 2,
    parameter int MAX_CREDIT = 6,
    parameter int CREDIT_W   = 4,
    parameter int ACK_TO     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c,
    input  logic                r,
    input  logic                cancel,
    input  logic                ack,
    output logic                L,
    output logic                chg_r,
    output logic                chg_c,
    output logic                rej,
    output logic                vend_fail,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TO_W = $clog2(ACK_TO + 1);

    localparam logic [CREDIT_W:0]   C_SUM     = (CREDIT_W+1)'(VAL_C);
    localparam logic [CREDIT_W:0]   R_SUM     = (CREDIT_W+1)'(VAL_R);
    localparam logic [CREDIT_W:0]   PRICE_SUM = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_CR  = CREDIT_W'(PRICE);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(ACK_TO - 1);

    logic [1:0]          state_q, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [TO_W-1:0]     cnt_q, cnt_nxt;
    logic                rej_q, rej_nxt;
    logic                chg_r_q, chg_r_nxt;
    logic                chg_c_q, chg_c_nxt;
    logic                fail_q, fail_nxt;

    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   sum_less_price;
    logic                co_r, co_c;
    logic [CREDIT_W-1:0] co_credit;

    assign sum            = {1'b0, credit_q} + (c ? C_SUM : '0) + (r ? R_SUM : '0);
    assign sum_less_price = sum - PRICE_SUM;

    vend_change_out #(.W(CREDIT_W)) u_change (
        .credit     (credit_q),
        .chg_r      (co_r),
        .chg_c      (co_c),
        .credit_nxt (co_credit)
    );

    // State, credit, timeout counter and registered output pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            cnt_q    <= '0;
            rej_q    <= 1'b0;
            chg_r_q  <= 1'b0;
            chg_c_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            credit_q <= credit_nxt;
            cnt_q    <= cnt_nxt;
            rej_q    <= rej_nxt;
            chg_r_q  <= chg_r_nxt;
            chg_c_q  <= chg_c_nxt;
            fail_q   <= fail_nxt;
        end
    end

    // Next state, next credit and the pulses to be registered on this edge
    always_comb begin
        state_nxt  = state_q;
        credit_nxt = credit_q;
        cnt_nxt    = '0;
        rej_nxt    = 1'b0;
        chg_r_nxt  = 1'b0;
        chg_c_nxt  = 1'b0;
        fail_nxt   = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (sum > MAX_SUM) begin
                    // Both coins bounce; credit holds
                    rej_nxt = 1'b1;
                end else if (cancel && state_q == COLLECT) begin
                    // Refund everything including coins landing now; skip the price test
                    credit_nxt = sum[CREDIT_W-1:0];
                end else if (sum >= PRICE_SUM) begin
                    credit_nxt = sum_less_price[CREDIT_W-1:0];
                    state_nxt  = VEND;
                end else begin
                    credit_nxt = sum[CREDIT_W-1:0];
                    state_nxt  = (sum != '0) ? COLLECT : IDLE;
                end
                if (cancel && state_q == COLLECT) begin
                    state_nxt = CHANGE;
                end
            end
            VEND: begin
                rej_nxt = c | r;
                if (ack) begin
                    state_nxt = (credit_q != '0) ? CHANGE : IDLE;
                end else if (cnt_q == TO_LAST) begin
                    // Product never confirmed: give the price back with the change
                    fail_nxt   = 1'b1;
                    credit_nxt = credit_q + PRICE_CR;
                    state_nxt  = CHANGE;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                rej_nxt = c | r;
                if (credit_q == '0) begin
                    state_nxt = IDLE;
                end else begin
                    credit_nxt = co_credit;
                    chg_r_nxt  = co_r;
                    chg_c_nxt  = co_c;
                end
            end
        endcase
    end

    // Moore outputs decoded from registered state
    always_comb begin
        L         = (state_q == VEND);
        busy      = (state_q == VEND) || (state_q == CHANGE);
        chg_r     = chg_r_q;
        chg_c     = chg_c_q;
        rej       = rej_q;
        vend_fail = fail_q;
        credit    = credit_q;
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// tb/tb_vending_ctrl.sv - directed self-checking bench for vending_ctrl
module tb_vending_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       c = 1'b0, r = 1'b0, cancel = 1'b0, ack = 1'b0;
    logic       L, chg_r, chg_c, rej, vend_fail, busy;
    logic [3:0] credit;

    logic       c6 = 1'b0, r6 = 1'b0, cancel6 = 1'b0, ack6 = 1'b0;
    logic       L6, chg_r6, chg_c6, rej6, vend_fail6, busy6;
    logic [3:0] credit6;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vending_ctrl #(.PRICE(2), .MAX_CREDIT(6), .CREDIT_W(4), .ACK_TO(8)) dut (
        .clk(clk), .rst(rst), .c(c), .r(r), .cancel(cancel), .ack(ack),
        .L(L), .chg_r(chg_r), .chg_c(chg_c), .rej(rej), .vend_fail(vend_fail),
        .credit(credit), .busy(busy)
    );

    vending_ctrl #(.PRICE(6), .MAX_CREDIT(6), .CREDIT_W(4), .ACK_TO(8)) dut6 (
        .clk(clk), .rst(rst), .c(c6), .r(r6), .cancel(cancel6), .ack(ack6),
        .L(L6), .chg_r(chg_r6), .chg_c(chg_c6), .rej(rej6), .vend_fail(vend_fail6),
        .credit(credit6), .busy(busy6)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock edge, then sample 1 time unit later and release all pulse inputs
    task automatic tick();
        @(posedge clk);
        #1;
        c = 1'b0; r = 1'b0; cancel = 1'b0; ack = 1'b0;
        c6 = 1'b0; r6 = 1'b0; ack6 = 1'b0;
    endtask

    task automatic drive(input logic ic, input logic ir, input logic icn, input logic ia);
        c = ic; r = ir; cancel = icn; ack = ia;
        tick();
    endtask

    task automatic drive6(input logic ic, input logic ir, input logic ia);
        c6 = ic; r6 = ir; ack6 = ia;
        tick();
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("rst_credit", credit, 0);
        check("rst_L", L, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {chg_r, chg_c, rej, vend_fail}, 0);
        rst = 1'b0;

        // c, c -> vend at PRICE 2, ack -> IDLE, no change
        drive(1, 0, 0, 0);
        check("cc_credit1", credit, 1);
        check("cc_L_low", L, 0);
        drive(1, 0, 0, 0);
        check("cc_credit0", credit, 0);
        check("cc_L_high", L, 1);
        check("cc_busy", busy, 1);
        drive(0, 0, 0, 1);
        check("cc_ack_L", L, 0);
        check("cc_ack_busy", busy, 0);
        drive(0, 0, 0, 0);
        check("cc_no_change", {chg_r, chg_c}, 0);

        // cancel in IDLE is ignored
        drive(0, 0, 1, 0);
        check("idle_cancel_busy", busy, 0);
        check("idle_cancel_credit", credit, 0);

        // c+r together -> credit 1, VEND; ack -> one chg_c
        drive(1, 1, 0, 0);
        check("cr_credit", credit, 1);
        check("cr_L", L, 1);
        drive(0, 0, 0, 1);
        check("cr_ack_busy", busy, 1);
        check("cr_ack_L", L, 0);
        drive(0, 0, 0, 0);
        check("cr_chg", {chg_r, chg_c}, 1);
        check("cr_chg_credit", credit, 0);
        drive(0, 0, 0, 0);
        check("cr_idle", {busy, chg_r, chg_c}, 0);

        // c, then cancel with r -> credit 3 refunded as chg_r, chg_c
        drive(1, 0, 0, 0);
        check("cn_credit1", credit, 1);
        drive(0, 1, 1, 0);
        check("cn_credit3", credit, 3);
        check("cn_busy", busy, 1);
        check("cn_L", L, 0);
        drive(0, 0, 0, 0);
        check("cn_chg1", {chg_r, chg_c}, 2);
        check("cn_credit_after_r", credit, 1);
        check("cn_L2", L, 0);
        drive(0, 0, 0, 0);
        check("cn_chg2", {chg_r, chg_c}, 1);
        check("cn_credit_after_c", credit, 0);
        drive(0, 0, 0, 0);
        check("cn_idle", {busy, chg_r, chg_c, L}, 0);

        // Timeout: no ack for 8 cycles, coin during VEND is refused
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check("to_L", L, 1);
        drive(1, 0, 0, 0);
        check("to_rej", rej, 1);
        check("to_rej_credit", credit, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0);
            check("to_wait_L", L, 1);
            check("to_wait_fail", {vend_fail, rej}, 0);
        end
        drive(0, 0, 0, 0);
        check("to_fail", vend_fail, 1);
        check("to_fail_L", L, 0);
        check("to_fail_credit", credit, 2);
        check("to_fail_busy", busy, 1);
        drive(0, 0, 0, 0);
        check("to_chg", {chg_r, chg_c, vend_fail}, 4);
        check("to_chg_credit", credit, 0);
        drive(0, 0, 0, 0);
        check("to_idle", busy, 0);

        // PRICE 6 instance: r, r, r -> 2, 4, VEND with credit 0
        drive6(0, 1, 0);
        check("p6_credit2", credit6, 2);
        drive6(0, 1, 0);
        check("p6_credit4", credit6, 4);
        drive6(0, 1, 0);
        check("p6_vend_credit", credit6, 0);
        check("p6_vend_L", L6, 1);
        drive6(0, 0, 1);
        check("p6_ack_busy", busy6, 0);
        // Build credit 5, then overflowing coins are refused
        drive6(0, 1, 0);
        drive6(0, 1, 0);
        drive6(1, 0, 0);
        check("p6_credit5", credit6, 5);
        drive6(0, 1, 0);
        check("p6_ovf_rej", rej6, 1);
        check("p6_ovf_credit", credit6, 5);
        drive6(1, 1, 0);
        check("p6_ovf2_rej", rej6, 1);
        check("p6_ovf2_credit", credit6, 5);
        drive6(1, 0, 0);
        check("p6_exact_rej", rej6, 0);
        check("p6_exact_L", L6, 1);
        check("p6_exact_credit", credit6, 0);
        drive6(0, 0, 1);

        // Reset during CHANGE with credit 4 aborts immediately
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 0);
        check("ra_credit4", credit, 4);
        check("ra_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("ra_async_credit", credit, 0);
        check("ra_async_out", {L, chg_r, chg_c, rej, vend_fail, busy}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ra_quiet", {chg_r, chg_c, busy, L}, 0);
            check("ra_quiet_credit", credit, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
